// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-bus bridge: state encoding, frame levels
// and the counter-width helper.
package spi_bridge_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ADDR  = 3'd1;
    localparam state_t ST_WE    = 3'd2;
    localparam state_t ST_WDATA = 3'd3;
    localparam state_t ST_BUS   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_RDATA = 3'd6;

    localparam logic START_BIT  = 1'b0;
    localparam logic IDLE_LEVEL = 1'b1;

    // Bits needed to count up to max(a,b); never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_bridge_sync.sv
// Synchronises the asynchronous SPI clock and data pins into cw_clk and
// produces a one-cycle pulse on each rising edge of the synced SPI clock.
module spi_bridge_sync
    import spi_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic cw_clk,
    input  logic cw_rst,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic clk_rise,
    output logic mosi_sync
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_d;
    logic                   clk_prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign clk_sync_d[gi]  = spi_clk;
                assign mosi_sync_d[gi] = spi_mosi;
            end else begin : g_chain
                assign clk_sync_d[gi]  = clk_sync_q[gi-1];
                assign mosi_sync_d[gi] = mosi_sync_q[gi-1];
            end
        end
    endgenerate

    // Reset to the idle line level so leaving reset never fakes an edge.
    always_ff @(posedge cw_clk or posedge cw_rst) begin
        if (cw_rst) begin
            clk_sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
            mosi_sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            clk_prev_q  <= IDLE_LEVEL;
        end else begin
            clk_sync_q  <= clk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_rise  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_bus_bridge.sv
// SPI-slave frame decoder driving a single bus master port; read frames
// shift bus data back out on spi_miso, errors and timeouts end the frame.
module spi_bus_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic              cw_clk,
    input  logic              cw_rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    output logic              err_sticky
);

    localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
    localparam int TMO_W = cnt_width(TIMEOUT, 0);

    logic clk_rise;
    logic mosi_s;

    spi_bridge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .cw_clk   (cw_clk),
        .cw_rst   (cw_rst),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .clk_rise (clk_rise),
        .mosi_sync(mosi_s)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              req_q, req_d;
    logic              miso_q, miso_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_inc;
    logic              tmo_expired;

    assign tmo_inc     = tmo_q + TMO_W'(1);
    assign tmo_expired = (TIMEOUT != 0) && (tmo_inc == TMO_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        req_d   = req_q;
        miso_d  = miso_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (clk_rise && mosi_s == START_BIT) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                    miso_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_ADDR: begin
                // LSB-first fields shift in from the top so bit 0 lands last at [0].
                if (clk_rise) begin
                    addr_d = {mosi_s, addr_q[ADDR_W-1:1]};
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d = ST_WE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WE: begin
                if (clk_rise) begin
                    we_d  = mosi_s;
                    cnt_d = '0;
                    if (mosi_s) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_BUS;
                        req_d   = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            ST_WDATA: begin
                if (clk_rise) begin
                    wdata_d = {mosi_s, wdata_q[DATA_W-1:1]};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ST_BUS;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_BUS: begin
                tmo_d = tmo_inc;
                if (bus_err || tmo_expired) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    miso_d  = 1'b0;
                end else if (bus_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    rdata_d = bus_rdata;
                    miso_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if (clk_rise) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RDATA;
                        miso_d  = rdata_q[0];
                        rdata_d = rdata_q >> 1;
                    end
                end
            end
            ST_RDATA: begin
                if (clk_rise) begin
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        miso_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        miso_d  = rdata_q[0];
                        rdata_d = rdata_q >> 1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                req_d   = 1'b0;
                miso_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cw_clk or posedge cw_rst) begin
        if (cw_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            miso_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            req_q   <= req_d;
            miso_q  <= miso_d;
            err_q   <= err_d;
        end
    end

    assign spi_miso   = miso_q;
    assign bus_req    = req_q;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed bench for spi_bus_bridge: table of single frames plus hand-written
// timeout, reset and back-to-back sequences against a bus responder.
module tb_spi_bus_bridge;
    import spi_bridge_pkg::*;

    localparam int HALF = 4;

    logic cw_clk = 1'b0;
    logic cw_rst;
    always #5 cw_clk = ~cw_clk;

    logic sclk, smosi, sel;
    logic ack, err;
    logic [15:0] rdata;

    logic spi_clk0, spi_clk1, ack0, ack1, err0, err1;
    assign spi_clk0 = sel ? 1'b1 : sclk;
    assign spi_clk1 = sel ? sclk : 1'b1;
    assign ack0 = sel ? 1'b0 : ack;
    assign ack1 = sel ? ack : 1'b0;
    assign err0 = sel ? 1'b0 : err;
    assign err1 = sel ? err : 1'b0;

    logic miso0, req0, we0, errs0, miso1, req1, we1, errs1;
    logic [23:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;

    spi_bus_bridge dut0 (
        .cw_clk(cw_clk), .cw_rst(cw_rst), .spi_clk(spi_clk0), .spi_mosi(smosi),
        .spi_miso(miso0), .bus_req(req0), .bus_we(we0), .bus_addr(addr0),
        .bus_wdata(wdata0), .bus_rdata(rdata), .bus_ack(ack0), .bus_err(err0),
        .err_sticky(errs0)
    );

    spi_bus_bridge #(.TIMEOUT(15)) dut1 (
        .cw_clk(cw_clk), .cw_rst(cw_rst), .spi_clk(spi_clk1), .spi_mosi(smosi),
        .spi_miso(miso1), .bus_req(req1), .bus_we(we1), .bus_addr(addr1),
        .bus_wdata(wdata1), .bus_rdata(rdata), .bus_ack(ack1), .bus_err(err1),
        .err_sticky(errs1)
    );

    logic miso_m, req_m, we_m, err_m;
    logic [23:0] addr_m;
    logic [15:0] wdata_m;
    assign miso_m  = sel ? miso1 : miso0;
    assign req_m   = sel ? req1 : req0;
    assign we_m    = sel ? we1 : we0;
    assign err_m   = sel ? errs1 : errs0;
    assign addr_m  = sel ? addr1 : addr0;
    assign wdata_m = sel ? wdata1 : wdata0;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wd;
    } txn_t;

    txn_t log_q[$];
    txn_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Responder: 0 = never answer, 1 = ack, 2 = err, 3 = ack and err together.
    int resp_mode = 0;
    int resp_lat  = 1;
    int req_cnt   = 0;
    bit in_req    = 0;

    initial begin
        ack = 1'b0;
        err = 1'b0;
        forever begin
            @(negedge cw_clk);
            ack = 1'b0;
            err = 1'b0;
            if (req_m === 1'b1) begin
                if (!in_req) begin
                    txn_t t;
                    in_req  = 1;
                    req_cnt = 0;
                    t.we   = we_m;
                    t.addr = addr_m;
                    t.wd   = wdata_m;
                    log_q.push_back(t);
                end
                req_cnt++;
                if (req_cnt == resp_lat) begin
                    if (resp_mode == 1 || resp_mode == 3) ack = 1'b1;
                    if (resp_mode == 2 || resp_mode == 3) err = 1'b1;
                end
            end else begin
                in_req = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        sclk  = 1'b0;
        smosi = b;
        repeat (HALF) @(negedge cw_clk);
        sclk = 1'b1;
        repeat (HALF) @(negedge cw_clk);
    endtask

    task automatic run_frame(input logic we, input logic [23:0] addr, input logic [15:0] wd,
                             input int extra, output logic [15:0] rd);
        int n;
        spi_bit(START_BIT);
        chk("start_miso_high", {31'd0, miso_m}, 32'd1);
        chk("start_clears_err", {31'd0, err_m}, 32'd0);
        for (int i = 0; i < 24; i++) spi_bit(addr[i]);
        spi_bit(we);
        if (we) for (int i = 0; i < 16; i++) spi_bit(wd[i]);
        repeat (extra) spi_bit(1'b1);
        n = 0;
        while (miso_m === 1'b1 && n < 5000) begin
            @(negedge cw_clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL miso_busy_wait actual=stuck_high required=low_within_5000");
        end
        spi_bit(1'b1);
        rd = '0;
        if (!we) begin
            for (int i = 0; i < 16; i++) begin
                rd[i] = miso_m;
                spi_bit(1'b1);
            end
        end
        repeat (4) @(negedge cw_clk);
    endtask

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wd;
        int          mode;
        int          lat;
        logic [15:0] rdata;
        logic        exp_err;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] rd;
        txn_t t;
        txn_t e;

        vecs[0] = '{1'b1, 24'h800011, 16'h3888, 1, 5,  16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 24'h000034, 16'h0000, 1, 5,  16'hA5C3, 1'b0, 16'hA5C3};
        vecs[2] = '{1'b1, 24'h123456, 16'hBEEF, 2, 3,  16'h0000, 1'b1, 16'h0000};
        vecs[3] = '{1'b0, 24'h00ABCD, 16'h0000, 1, 1,  16'h8001, 1'b0, 16'h8001};
        vecs[4] = '{1'b0, 24'hFFFFFF, 16'h0000, 3, 2,  16'h1234, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 24'h000000, 16'hFFFF, 1, 20, 16'h0000, 1'b0, 16'h0000};

        cw_rst = 1'b1;
        sclk   = 1'b1;
        smosi  = 1'b1;
        sel    = 1'b0;
        rdata  = '0;
        repeat (3) @(negedge cw_clk);
        chk("reset_miso",  {31'd0, miso0}, 32'd0);
        chk("reset_req",   {31'd0, req0}, 32'd0);
        chk("reset_we",    {31'd0, we0}, 32'd0);
        chk("reset_addr",  {8'd0, addr0}, 32'd0);
        chk("reset_wdata", {16'd0, wdata0}, 32'd0);
        chk("reset_err",   {31'd0, errs0}, 32'd0);
        cw_rst = 1'b0;
        repeat (4) @(negedge cw_clk);

        for (int v = 0; v < 6; v++) begin
            log_q.delete();
            resp_mode = vecs[v].mode;
            resp_lat  = vecs[v].lat;
            rdata     = vecs[v].rdata;
            run_frame(vecs[v].we, vecs[v].addr, vecs[v].wd, 0, rd);
            $display("vec %0d we=%0b addr=%h wd=%h mode=%0d lat=%0d rd=%h err=%0b",
                     v, vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].mode, vecs[v].lat, rd, err_m);
            chk("vec_one_bus_cycle", log_q.size(), 32'd1);
            if (log_q.size() > 0) begin
                t = log_q.pop_front();
                chk("vec_bus_we", {31'd0, t.we}, {31'd0, vecs[v].we});
                chk("vec_bus_addr", {8'd0, t.addr}, {8'd0, vecs[v].addr});
                if (vecs[v].we) chk("vec_bus_wdata", {16'd0, t.wd}, {16'd0, vecs[v].wd});
            end
            chk("vec_req_cycles", req_cnt, vecs[v].lat);
            chk("vec_err_sticky", {31'd0, err_m}, {31'd0, vecs[v].exp_err});
            if (!vecs[v].we) chk("vec_read_data", {16'd0, rd}, {16'd0, vecs[v].exp_rd});
            chk("vec_req_low", {31'd0, req_m}, 32'd0);
            chk("vec_miso_low", {31'd0, miso_m}, 32'd0);
            chk("vec_state_idle", {29'd0, dut0.state_q}, {29'd0, ST_IDLE});
        end

        // Timeout on the TIMEOUT=15 instance, with an ignored clock during BUS.
        sel = 1'b1;
        log_q.delete();
        resp_mode = 0;
        resp_lat  = 1;
        rdata     = 16'hFFFF;
        run_frame(1'b0, 24'h000077, 16'h0000, 1, rd);
        $display("timeout read addr=000077 req_cycles=%0d rd=%h err=%0b", req_cnt, rd, err_m);
        chk("tmo_req_cycles", req_cnt, 32'd15);
        chk("tmo_err_sticky", {31'd0, errs1}, 32'd1);
        chk("tmo_read_zero", {16'd0, rd}, 32'd0);
        chk("tmo_state_idle", {29'd0, dut1.state_q}, {29'd0, ST_IDLE});
        if (log_q.size() > 0) begin
            t = log_q.pop_front();
            chk("tmo_bus_addr", {8'd0, t.addr}, 32'h000077);
            chk("tmo_bus_we", {31'd0, t.we}, 32'd0);
        end else begin
            chk("tmo_bus_cycle_seen", log_q.size(), 32'd1);
        end
        sel = 1'b0;
        repeat (4) @(negedge cw_clk);

        // Reset after ten address bits, then a clean write.
        resp_mode = 1;
        resp_lat  = 3;
        log_q.delete();
        spi_bit(START_BIT);
        for (int i = 0; i < 10; i++) spi_bit(1'b1);
        chk("pre_reset_busy", {31'd0, miso0}, 32'd1);
        #2 cw_rst = 1'b1;
        #1;
        chk("midrst_miso",  {31'd0, miso0}, 32'd0);
        chk("midrst_req",   {31'd0, req0}, 32'd0);
        chk("midrst_we",    {31'd0, we0}, 32'd0);
        chk("midrst_addr",  {8'd0, addr0}, 32'd0);
        chk("midrst_wdata", {16'd0, wdata0}, 32'd0);
        chk("midrst_err",   {31'd0, errs0}, 32'd0);
        chk("midrst_state", {29'd0, dut0.state_q}, {29'd0, ST_IDLE});
        @(negedge cw_clk);
        cw_rst = 1'b0;
        repeat (4) @(negedge cw_clk);
        run_frame(1'b1, 24'h800000, 16'h000e, 0, rd);
        $display("post-reset write addr=800000 wd=000e bus_cycles=%0d", log_q.size());
        chk("postrst_one_cycle", log_q.size(), 32'd1);
        if (log_q.size() > 0) begin
            t = log_q.pop_front();
            chk("postrst_addr", {8'd0, t.addr}, 32'h800000);
            chk("postrst_wdata", {16'd0, t.wd}, 32'h0000000e);
            chk("postrst_we", {31'd0, t.we}, 32'd1);
        end
        chk("postrst_err", {31'd0, errs0}, 32'd0);

        // Back-to-back writes with random ack latency.
        log_q.delete();
        exp_q.delete();
        resp_mode = 1;
        for (int f = 0; f < 40; f++) begin
            e.we   = 1'b1;
            e.addr = 24'($urandom);
            e.wd   = 16'($urandom);
            exp_q.push_back(e);
            resp_lat = $urandom_range(1, 20);
            run_frame(1'b1, e.addr, e.wd, 0, rd);
            $display("b2b %0d addr=%h wd=%h lat=%0d", f, e.addr, e.wd, resp_lat);
            spi_bit(1'b1);
        end
        chk("b2b_count", log_q.size(), 32'd40);
        for (int f = 0; f < 40 && log_q.size() > 0; f++) begin
            t = log_q.pop_front();
            e = exp_q.pop_front();
            chk("b2b_addr", {8'd0, t.addr}, {8'd0, e.addr});
            chk("b2b_wdata", {16'd0, t.wd}, {16'd0, e.wd});
        end
        chk("b2b_err", {31'd0, errs0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
